// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler
//   Sequencing controller for a 4-digit multiplexed 7-segment display.
//   A 16-bit value arrives over a valid/ready handshake. Decimal values are
//   converted to BCD by iterative double-dabble at one bit per cycle. Hex
//   values are used as nibbles directly. The digits are committed atomically
//   to a display register. A scan engine then time-multiplexes the four digit
//   selects, using a programmable ON dwell and a fixed blanking gap.
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset
//   en        scan enable. When low, sel/seg are 0 and the scan state is held
//             at its reset values.
//   in_valid  new value offered
//   in_ready  high only while the converter is idle
//   in_value  value to display
//   in_hex    1: show hex nibbles, 0: show decimal. Captured with in_value.
//   dwell     ON cycles per digit (0 behaves as 1). Sampled when a digit starts.
//   sel       one-hot digit select; sel[0] is the least-significant digit
//   seg       segments a..g on bits 0..6, dp on bit 7 (always 0), active high
//   busy      converter is not idle
//   done      one-cycle pulse while a result is being committed
//   ovf       decimal value exceeded 9999 at the last commit
//
// Parameters
//   DEAD_CYCLES  blank cycles between digits (0..15); 0 removes the gap
//   DWELL_W      width of dwell and the scan counter
//
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN: when defined, blanks leading zeros in decimal
//   (non-overflow) mode. Digit 0 is always shown.
module seg7_scan_scheduler #(
    parameter int DEAD_CYCLES = 2,
    parameter int DWELL_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_value,
    input  logic               in_hex,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         sel,
    output logic [7:0]         seg,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    // The scan counter must hold both the dwell count and the blank count.
    localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    // ---------------- conversion FSM ----------------
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state_reg;
    logic [3:0]  bit_cnt_reg;
    logic [19:0] bcd_reg;         // 5 BCD digits; hex nibbles sit in [15:0]
    logic [15:0] src_reg;         // bits still to be shifted into the BCD field
    logic        hex_cap_reg;
    logic [15:0] disp_digits_reg; // committed digits, 4 bits each
    logic        disp_hex_reg;
    logic        ovf_reg;
    logic        in_ready_reg;
    logic        busy_reg;
    logic        done_reg;

    // Add-3 step of double-dabble, applied to every nibble before each shift.
    // The top nibble is kept to 3 bits because its MSB is shifted out.
    logic [18:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate
    assign bcd_adj[18:16] = 3'((bcd_reg[19:16] >= 4'd5) ? bcd_reg[19:16] + 4'd3 : bcd_reg[19:16]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            bcd_reg         <= '0;
            src_reg         <= '0;
            hex_cap_reg     <= 1'b0;
            disp_digits_reg <= '0;
            disp_hex_reg    <= 1'b0;
            ovf_reg         <= 1'b0;
            in_ready_reg    <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        hex_cap_reg  <= in_hex;
                        bit_cnt_reg  <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (in_hex) begin
                            // Hex needs no conversion; nibbles go straight to commit.
                            bcd_reg   <= {4'd0, in_value};
                            src_reg   <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= COMMIT;
                        end else begin
                            bcd_reg   <= '0;
                            src_reg   <= in_value;
                            state_reg <= CONV;
                        end
                    end
                end
                CONV: begin
                    {bcd_reg, src_reg} <= {bcd_adj, src_reg, 1'b0};
                    bit_cnt_reg        <= bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd15) begin
                        done_reg  <= 1'b1;
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_digits_reg <= bcd_reg[15:0];
                    disp_hex_reg    <= hex_cap_reg;
                    ovf_reg         <= !hex_cap_reg && (bcd_reg[19:16] != 4'd0);
                    done_reg        <= 1'b0;
                    in_ready_reg    <= 1'b1;
                    busy_reg        <= 1'b0;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready = in_ready_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign ovf      = ovf_reg;

    // ---------------- scan engine ----------------
    typedef enum logic {PH_ON, PH_BLANK} phase_t;

    phase_t             phase_reg;
    logic [1:0]         digit_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DWELL_W-1:0] dwell_len_reg;
    logic [DWELL_W-1:0] dwell_eff;
    logic [DWELL_W-1:0] cur_len;

    // The length of an ON phase is taken from dwell on its first cycle and then held.
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign cur_len   = (cnt_reg == '0) ? dwell_eff : dwell_len_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase_reg     <= PH_ON;
            digit_reg     <= 2'd0;
            cnt_reg       <= '0;
            dwell_len_reg <= DWELL_W'(1);
        end else begin
            case (phase_reg)
                PH_ON: begin
                    dwell_len_reg <= cur_len;
                    if (cnt_reg == CNT_W'(cur_len - DWELL_W'(1))) begin
                        cnt_reg <= '0;
                        if (DEAD_CYCLES == 0) begin
                            digit_reg <= digit_reg + 2'd1;
                        end else begin
                            phase_reg <= PH_BLANK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                PH_BLANK: begin
                    if (cnt_reg == DEAD_LAST) begin
                        cnt_reg   <= '0;
                        phase_reg <= PH_ON;
                        digit_reg <= digit_reg + 2'd1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: phase_reg <= PH_ON;
            endcase
        end
    end

    // ---------------- output decode ----------------
    function automatic logic [7:0] seg7_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'h0: c = 8'h3F;  4'h1: c = 8'h06;  4'h2: c = 8'h5B;  4'h3: c = 8'h4F;
            4'h4: c = 8'h66;  4'h5: c = 8'h6D;  4'h6: c = 8'h7D;  4'h7: c = 8'h07;
            4'h8: c = 8'h7F;  4'h9: c = 8'h6F;  4'hA: c = 8'h77;  4'hB: c = 8'h7C;
            4'hC: c = 8'h39;  4'hD: c = 8'h5E;  4'hE: c = 8'h79;  default: c = 8'h71;
        endcase
        return c;
    endfunction

    // A digit is a leading zero when it and every higher digit are zero.
    logic [3:0] lz;
    assign lz[0] = 1'b0;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lz
            assign lz[gi] = LZB_ON && !disp_hex_reg && (disp_digits_reg[15:gi*4] == '0);
        end
    endgenerate

    always_comb begin
        sel = 4'b0000;
        seg = 8'h00;
        if (en && phase_reg == PH_ON) begin
            sel = 4'b0001 << digit_reg;
            if (ovf_reg) begin
                seg = 8'h40;
            end else if (lz[digit_reg]) begin
                seg = 8'h00;
            end else begin
                seg = seg7_code(disp_digits_reg[digit_reg*4 +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Testbench for seg7_scan_scheduler.
// The reference model expands each digit slot into a queue of per-cycle select
// entries and computes the displayed digits arithmetically from the value.
module tb_seg7_scan_scheduler;
    localparam int DEAD = 2;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, in_ready, in_hex, busy, done, ovf;
    logic [15:0] in_value;
    logic [7:0]  dwell;
    logic [3:0]  sel;
    logic [7:0]  seg;

    seg7_scan_scheduler #(.DEAD_CYCLES(DEAD), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_hex(in_hex), .dwell(dwell), .sel(sel), .seg(seg),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // reference model state
    int          q[$];          // per-cycle digit index, -1 = blank
    int          nd = 0;        // next digit to schedule
    int          pend = 0;      // edges until commit lands (0 = idle)
    bit [15:0]   m_val = 0, p_val = 0;
    bit          m_hex = 0, p_hex = 0;
    bit          accepted = 0;
    int          pw[4] = '{1, 10, 100, 1000};
    logic [7:0]  seg_tab[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic bit m_ovf();
        return !m_hex && (m_val > 9999);
    endfunction

    function automatic logic [7:0] exp_seg(int e);
        int d;
        if (e < 0) return 8'h00;
        if (m_ovf()) return 8'h40;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (!m_hex && e > 0 && int'(m_val) < pw[e]) return 8'h00;
`endif
        d = m_hex ? ((int'(m_val) >> (4 * e)) & 15) : ((int'(m_val) / pw[e]) % 10);
        return seg_tab[d];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic fill();
        if (q.size() == 0) begin
            int len = (dwell == 0) ? 1 : int'(dwell);
            repeat (len) q.push_back(nd);
            repeat (DEAD) q.push_back(-1);
            nd = (nd + 1) % 4;
        end
    endtask

    task automatic cycle();
        int e;
        @(negedge clk);
        if (chk_en) begin
            if (en) begin
                fill();
                e = q[0];
            end else begin
                e = -1;
            end
            check("sel", 32'(sel), (e < 0) ? 32'd0 : (32'd1 << e));
            check("seg", 32'(seg), 32'(exp_seg(e)));
            check("in_ready", 32'(in_ready), 32'(pend == 0));
            check("busy", 32'(busy), 32'(pend != 0));
            check("done", 32'(done), 32'(pend == 1));
            check("ovf", 32'(ovf), 32'(m_ovf()));
        end
        @(posedge clk);
        accepted = 0;
        if (rst) begin
            pend = 0; m_val = 0; m_hex = 0; q.delete(); nd = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin m_val = p_val; m_hex = p_hex; end
            end else if (in_valid) begin
                p_val = in_value; p_hex = in_hex;
                pend = in_hex ? 1 : 17;
                accepted = 1;
            end
            if (!en) begin
                q.delete(); nd = 0;
            end else begin
                fill();
                void'(q.pop_front());
            end
        end
        #1;
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    // Offer a value and hold in_valid until the handshake fires.
    task automatic send(bit [15:0] v, bit hx);
        int guard = 0;
        in_valid = 1'b1; in_value = v; in_hex = hx;
        do begin
            cycle();
            guard++;
        end while (!accepted && guard < 100);
        check("handshake_bound", 32'(accepted), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; dwell = 8'd3; in_valid = 1'b0; in_value = '0; in_hex = 1'b0;
        run(2);
        rst = 1'b0;
        chk_en = 1;

        // scan pattern from reset: dwell 3, two blank cycles, 20-cycle period
        run(45);
        // decimal conversion
        send(16'd1234, 1'b0);
        run(40);
        // hex nibbles
        send(16'hBEEF, 1'b1);
        run(25);
        // overflow, then cleared by a small decimal
        send(16'd12345, 1'b0);
        run(40);
        send(16'd7, 1'b0);
        run(40);
        // value held while busy is accepted on the first idle cycle
        send(16'd99, 1'b0);
        run(3);
        send(16'd42, 1'b0);
        run(30);
        // dwell 0 behaves as 1
        dwell = 8'd0;
        run(24);
        // randomized values, modes, dwells and gaps
        for (int i = 0; i < 20; i++) begin
            bit [15:0] v;
            dwell = 8'($urandom_range(0, 5));
            v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 120)) : 16'($urandom_range(0, 65535));
            send(v, 1'($urandom_range(0, 1)));
            run($urandom_range(0, 30));
        end
        dwell = 8'd2;
        // reset during conversion
        send(16'd5678, 1'b0);
        run(5);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(25);
        // scan disable holds the scan state at reset values
        send(16'd31, 1'b0);
        run(23);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
